// File: rtl/keypad_pkg.sv
// Shared definitions for the TTP229 keypad scanner and its display-side users:
// scan FSM states, default two-wire timing, and the phase-counter sizing helper.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_DV  = 3'd1,
    WAIT_TW  = 3'd2,
    CLK_LOW  = 3'd3,
    CLK_HIGH = 3'd4,
    GAP      = 3'd5
  } scan_state_t;

  localparam int DEF_T_DV   = 93;
  localparam int DEF_T_TW   = 10;
  localparam int DEF_T_HALF = 250;
  localparam int DEF_T_GAP  = 2000;

  // Width of a counter that must reach (longest phase - 1).
  function automatic int phase_cnt_width(input int t_gap, input int t_half,
                                         input int t_dv, input int t_tw);
    int m;
    m = t_gap;
    if (t_half > m) m = t_half;
    if (t_dv > m)   m = t_dv;
    if (t_tw > m)   m = t_tw;
    if (m < 2)      m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/keypad_prio_enc.sv
// Lowest-index priority encoder: o_idx is the smallest i with i_vec[i] set,
// o_any flags that at least one bit is set. o_idx is 0 when nothing is set.
module keypad_prio_enc #(
  parameter int N  = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Scan from the top down so the lowest set index is written last and wins.
  always_comb begin
    o_idx = {IW{1'b0}};
    o_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = IW'(i);
        o_any = 1'b1;
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/ttp229_scan_ctrl.sv
// TTP229-BSF two-wire scanner: drives SCL, samples SDO once per key, debounces
// whole frames and reports the lowest newly pressed key as a one-cycle event.
module ttp229_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int N_KEYS     = 16,
  parameter int T_DV       = DEF_T_DV,
  parameter int T_TW       = DEF_T_TW,
  parameter int T_HALF     = DEF_T_HALF,
  parameter int T_GAP      = DEF_T_GAP,
  parameter int ACTIVE_LOW = 1,
  parameter int DEB_FRAMES = 2
) (
  input  logic              CLOCK_1M,
  input  logic              resetn,
  input  logic              scan_en_i,
  input  logic              sdo_i,
  output logic              scl_o,
  output logic [N_KEYS-1:0] key_o,
  output logic              key_any_o,
  output logic              key_valid_o,
  output logic [3:0]        key_idx_o,
  output logic              frame_done_o
);

  localparam int CW = phase_cnt_width(T_GAP, T_HALF, T_DV, T_TW);
  localparam int BW = $clog2(N_KEYS);

  localparam logic [CW-1:0] L_CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] L_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] L_END_DV   = CW'(T_DV - 1);
  localparam logic [CW-1:0] L_END_TW   = CW'(T_TW - 1);
  localparam logic [CW-1:0] L_END_HALF = CW'(T_HALF - 1);
  localparam logic [CW-1:0] L_END_GAP  = CW'(T_GAP - 1);
  localparam logic [BW-1:0] L_BIT_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] L_BIT_LAST = BW'(N_KEYS - 1);
  localparam logic          L_INVERT   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [2:0]    L_DEB      = 3'(DEB_FRAMES);

  scan_state_t       r_state;
  scan_state_t       w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [BW-1:0]     r_bit;
  logic [BW-1:0]     w_bit_nxt;
  logic              w_sample;
  logic              w_done_nxt;
  logic              w_scl_nxt;
  logic              w_raw_bit;

  logic              r_scl;
  logic              r_done;
  logic [N_KEYS-1:0] r_raw;
  logic [N_KEYS-1:0] r_last_raw;
  logic [2:0]        r_match;
  logic [2:0]        w_match_nxt;
  logic              w_load;
  logic [N_KEYS-1:0] w_new;
  logic [BW-1:0]     w_enc_idx;
  logic              w_enc_any;
  logic [N_KEYS-1:0] r_key;
  logic              r_any;
  logic              r_valid;
  logic [3:0]        r_idx;

  // A pressed key always ends up as raw bit 1 regardless of SDO polarity.
  assign w_raw_bit = sdo_i ^ L_INVERT;

  // Scan sequencing: each phase holds for its parameter count, then advances.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + L_CNT_ONE;
    w_bit_nxt   = r_bit;
    w_sample    = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = L_CNT_ZERO;
        if (scan_en_i) w_state_nxt = WAIT_DV;
        else           w_state_nxt = IDLE;
      end
      WAIT_DV: begin
        if (r_cnt == L_END_DV) begin
          w_state_nxt = WAIT_TW;
          w_cnt_nxt   = L_CNT_ZERO;
        end else begin
          w_state_nxt = WAIT_DV;
        end
      end
      WAIT_TW: begin
        if (r_cnt == L_END_TW) begin
          w_state_nxt = CLK_LOW;
          w_cnt_nxt   = L_CNT_ZERO;
        end else begin
          w_state_nxt = WAIT_TW;
        end
      end
      CLK_LOW: begin
        if (r_cnt == L_END_HALF) begin
          w_state_nxt = CLK_HIGH;
          w_cnt_nxt   = L_CNT_ZERO;
        end else begin
          w_state_nxt = CLK_LOW;
        end
      end
      CLK_HIGH: begin
        if (r_cnt == L_END_HALF) begin
          w_sample  = 1'b1;
          w_cnt_nxt = L_CNT_ZERO;
          if (r_bit == L_BIT_LAST) begin
            w_state_nxt = GAP;
            w_bit_nxt   = L_BIT_ZERO;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = CLK_LOW;
            w_bit_nxt   = r_bit + BW'(1);
          end
        end else begin
          w_state_nxt = CLK_HIGH;
        end
      end
      GAP: begin
        if (r_cnt == L_END_GAP) begin
          w_cnt_nxt = L_CNT_ZERO;
          if (scan_en_i) w_state_nxt = WAIT_DV;
          else           w_state_nxt = IDLE;
        end else begin
          w_state_nxt = GAP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = L_CNT_ZERO;
        w_bit_nxt   = L_BIT_ZERO;
      end
    endcase
    if (w_state_nxt == CLK_LOW) w_scl_nxt = 1'b0;
    else                        w_scl_nxt = 1'b1;
  end

  // Scan state, counters, SCL and raw frame capture; reset aborts a frame at once.
  always_ff @(posedge CLOCK_1M or posedge resetn) begin
    if (resetn) begin
      r_state <= IDLE;
      r_cnt   <= L_CNT_ZERO;
      r_bit   <= L_BIT_ZERO;
      r_scl   <= 1'b1;
      r_done  <= 1'b0;
      r_raw   <= {N_KEYS{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_scl   <= w_scl_nxt;
      r_done  <= w_done_nxt;
      if (w_sample) r_raw[r_bit] <= w_raw_bit;
    end
  end

  // Only keys that are pressed now but were not in the reported vector count as new.
  assign w_new = r_raw & ~r_key;

  keypad_prio_enc #(.N(N_KEYS)) u_prio_enc (
    .i_vec (w_new),
    .o_idx (w_enc_idx),
    .o_any (w_enc_any)
  );

  // Frame-match counting and the decision to publish the new raw frame.
  always_comb begin
    w_match_nxt = r_match;
    w_load      = 1'b0;
    if (r_raw == r_last_raw) begin
      if (r_match == 3'd7) w_match_nxt = 3'd7;
      else                 w_match_nxt = r_match + 3'd1;
    end else begin
      w_match_nxt = 3'd1;
    end
    if (r_done && (w_match_nxt >= L_DEB) && (r_raw != r_key)) w_load = 1'b1;
    else                                                     w_load = 1'b0;
  end

  // Debounce history plus registered key vector and press event, one cycle after frame end.
  always_ff @(posedge CLOCK_1M or posedge resetn) begin
    if (resetn) begin
      r_last_raw <= {N_KEYS{1'b0}};
      r_match    <= 3'd0;
      r_key      <= {N_KEYS{1'b0}};
      r_any      <= 1'b0;
      r_valid    <= 1'b0;
      r_idx      <= 4'd0;
    end else begin
      r_valid <= 1'b0;
      if (r_done) begin
        r_last_raw <= r_raw;
        r_match    <= w_match_nxt;
      end
      if (w_load) begin
        r_key <= r_raw;
        r_any <= |r_raw;
        if (w_enc_any) begin
          r_valid <= 1'b1;
          r_idx   <= 4'(w_enc_idx);
        end
      end
    end
  end

  assign scl_o        = r_scl;
  assign frame_done_o = r_done;
  assign key_o        = r_key;
  assign key_any_o    = r_any;
  assign key_valid_o  = r_valid;
  assign key_idx_o    = r_idx;

endmodule

// File: tb/tb_ttp229_scan_ctrl.sv
// Self-checking bench for ttp229_scan_ctrl: a keypad model answers SCL with SDO
// from a per-frame press pattern; expected debounced results are queued per frame.
module tb_ttp229_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: all defaults.
  logic rst_a = 1'b1, en_a = 1'b0, sdo_a, scl_a, any_a, val_a, done_a;
  logic [15:0] key_a;
  logic [3:0]  idx_a;
  // Instance B: 16 keys, active-low SDO, short timing.
  logic rst_b = 1'b1, en_b = 1'b0, sdo_b, scl_b, any_b, val_b, done_b;
  logic [15:0] key_b;
  logic [3:0]  idx_b;
  // Instance C: 8 keys, active-high SDO, T_HALF=4.
  logic rst_c = 1'b1, en_c = 1'b0, sdo_c = 1'b0, scl_c, any_c, val_c, done_c;
  logic [7:0]  key_c;
  logic [3:0]  idx_c;

  ttp229_scan_ctrl u_a (
    .CLOCK_1M(clk), .resetn(rst_a), .scan_en_i(en_a), .sdo_i(sdo_a), .scl_o(scl_a),
    .key_o(key_a), .key_any_o(any_a), .key_valid_o(val_a), .key_idx_o(idx_a),
    .frame_done_o(done_a));

  ttp229_scan_ctrl #(.N_KEYS(16), .T_DV(5), .T_TW(3), .T_HALF(4), .T_GAP(10),
                     .ACTIVE_LOW(1), .DEB_FRAMES(2)) u_b (
    .CLOCK_1M(clk), .resetn(rst_b), .scan_en_i(en_b), .sdo_i(sdo_b), .scl_o(scl_b),
    .key_o(key_b), .key_any_o(any_b), .key_valid_o(val_b), .key_idx_o(idx_b),
    .frame_done_o(done_b));

  ttp229_scan_ctrl #(.N_KEYS(8), .ACTIVE_LOW(0), .T_HALF(4)) u_c (
    .CLOCK_1M(clk), .resetn(rst_c), .scan_en_i(en_c), .sdo_i(sdo_c), .scl_o(scl_c),
    .key_o(key_c), .key_any_o(any_c), .key_valid_o(val_c), .key_idx_o(idx_c),
    .frame_done_o(done_c));

  int sel = 0;
  logic mon_scl, mon_done, mon_rst, mon_any, mon_val;
  logic [15:0] mon_key;
  logic [3:0]  mon_idx;
  assign mon_scl  = (sel == 2) ? scl_c  : (sel == 1) ? scl_b  : scl_a;
  assign mon_done = (sel == 2) ? done_c : (sel == 1) ? done_b : done_a;
  assign mon_rst  = (sel == 2) ? rst_c  : (sel == 1) ? rst_b  : rst_a;
  assign mon_any  = (sel == 2) ? any_c  : (sel == 1) ? any_b  : any_a;
  assign mon_val  = (sel == 2) ? val_c  : (sel == 1) ? val_b  : val_a;
  assign mon_idx  = (sel == 2) ? idx_c  : (sel == 1) ? idx_b  : idx_a;
  assign mon_key  = (sel == 2) ? {8'h00, key_c} : (sel == 1) ? key_b : key_a;

  // Keypad model: count SCL falling edges in the frame; bit k is presented after fall k+1.
  int   falls;
  logic prev_scl;
  always @(posedge clk or posedge mon_rst) begin
    if (mon_rst) begin
      falls    <= 0;
      prev_scl <= 1'b1;
    end else begin
      prev_scl <= mon_scl;
      if (mon_done) falls <= 0;
      else if (prev_scl && !mon_scl) falls <= falls + 1;
    end
  end

  logic [15:0] pat = 16'h0000;
  logic [3:0]  w_bit;
  logic        pbit;
  assign w_bit = 4'(falls - 1);
  assign pbit  = (falls >= 1 && falls <= 16) ? pat[w_bit] : 1'b0;
  assign sdo_a = ~pbit;
  assign sdo_b = ~pbit;

  typedef struct {
    logic [15:0] press;
    logic [15:0] key;
    logic        any;
    logic        valid;
    logic [3:0]  idx;
  } vec_t;

  vec_t sb_q[$];
  vec_t vt[13];
  int   n_vec = 0;
  int   n_bad = 0;
  int   run_len[64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mon_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Pop the frame's expectation when the DUT finishes it; compare on the update cycle.
  task automatic frame_check(input string nm, input int budget);
    bit   ok;
    vec_t e;
    wait_done(budget, ok);
    if (sb_q.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sb_q.pop_front();
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL %s: frame_done timeout", nm);
      return;
    end
    @(negedge clk);
    chk($sformatf("%s.key", nm),   32'(mon_key), 32'(e.key));
    chk($sformatf("%s.any", nm),   32'(mon_any), 32'(e.any));
    chk($sformatf("%s.valid", nm), 32'(mon_val), 32'(e.valid));
    chk($sformatf("%s.idx", nm),   32'(mon_idx), 32'(e.idx));
    if (e.valid) begin
      @(negedge clk);
      chk($sformatf("%s.pulse1", nm), 32'(mon_val), 32'd0);
    end
  endtask

  initial begin
    int   nruns, cur, done_idx, done_cnt, first_low;
    int   low_samp, low_runs, min_run, max_run;
    bit   ok;
    logic s, prev;

    vt[0]  = '{16'h0208, 16'h0000, 1'b0, 1'b0, 4'd0};
    vt[1]  = '{16'h0208, 16'h0208, 1'b1, 1'b1, 4'd3};
    vt[2]  = '{16'h0208, 16'h0208, 1'b1, 1'b0, 4'd3};
    vt[3]  = '{16'h0000, 16'h0208, 1'b1, 1'b0, 4'd3};
    vt[4]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 4'd3};
    vt[5]  = '{16'h0080, 16'h0000, 1'b0, 1'b0, 4'd3};
    vt[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 4'd3};
    vt[7]  = '{16'h0080, 16'h0000, 1'b0, 1'b0, 4'd3};
    vt[8]  = '{16'h0080, 16'h0080, 1'b1, 1'b1, 4'd7};
    vt[9]  = '{16'hFFFF, 16'h0080, 1'b1, 1'b0, 4'd7};
    vt[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 4'd0};
    vt[11] = '{16'h8000, 16'hFFFF, 1'b1, 1'b0, 4'd0};
    vt[12] = '{16'h8000, 16'h8000, 1'b1, 1'b0, 4'd0};

    // Reset state and frame timing with defaults.
    sel = 0; pat = 16'h0000; en_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.scl",   32'(scl_a),  32'd1);
    chk("rst.key",   32'(key_a),  32'd0);
    chk("rst.any",   32'(any_a),  32'd0);
    chk("rst.valid", 32'(val_a),  32'd0);
    chk("rst.idx",   32'(idx_a),  32'd0);
    chk("rst.done",  32'(done_a), 32'd0);
    rst_a = 1'b0;
    nruns = 0; cur = 0; done_idx = -1; done_cnt = 0; prev = 1'b1;
    for (int i = 1; i <= 10300; i++) begin
      @(negedge clk);
      s = scl_a;
      if (i == 1) begin
        prev = s; cur = 1;
      end else if (s == prev) begin
        cur++;
      end else begin
        if (nruns < 64) run_len[nruns] = cur;
        nruns++; cur = 1; prev = s;
      end
      if (done_a) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
    end
    chk("t1.runs", 32'(nruns), 32'd33);
    chk("t1.dv_tw_high", 32'(run_len[0]), 32'd103);
    for (int k = 1; k <= 31; k++) chk($sformatf("t1.half%0d", k), 32'(run_len[k]), 32'd250);
    chk("t1.last_high_gap", 32'(run_len[32]), 32'd2353);
    chk("t1.done_at", 32'(done_idx), 32'd8104);
    chk("t1.done_cnt", 32'(done_cnt), 32'd1);
    rst_a = 1'b1;

    // Single key 5 held with default timing: event after frame 2 only.
    repeat (2) @(negedge clk);
    pat = 16'h0020;
    sb_q.push_back('{16'h0020, 16'h0000, 1'b0, 1'b0, 4'd0});
    sb_q.push_back('{16'h0020, 16'h0020, 1'b1, 1'b1, 4'd5});
    sb_q.push_back('{16'h0020, 16'h0020, 1'b1, 1'b0, 4'd5});
    rst_a = 1'b0;
    for (int f = 0; f < 3; f++) frame_check($sformatf("t2.f%0d", f), 12000);
    rst_a = 1'b1; en_a = 1'b0;

    // Table-driven frames on the fast instance: dual press, release, bounce, all-pressed.
    sel = 1; en_b = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      pat = vt[i].press;
      sb_q.push_back(vt[i]);
      if (i == 0) rst_b = 1'b0;
      frame_check($sformatf("vec%0d", i), 400);
    end

    // scan_en dropped at bit 4: frame completes, then idle until re-enabled.
    pat = 16'h0000;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (falls == 5) begin ok = 1'b1; break; end
    end
    chk("t5.reach_bit4", 32'(ok), 32'd1);
    en_b = 1'b0;
    wait_done(400, ok);
    chk("t5.done", 32'(ok), 32'd1);
    chk("t5.bits", 32'(falls), 32'd16);
    low_samp = 0;
    for (int i = 0; i < 438; i++) begin
      @(negedge clk);
      if (!scl_b) low_samp++;
    end
    chk("t5.idle_lows", 32'(low_samp), 32'd0);
    en_b = 1'b1;
    first_low = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (!scl_b && first_low < 0) first_low = i;
    end
    chk("t5.restart", 32'(first_low), 32'd9);
    rst_b = 1'b1;

    // 8-key active-high instance: load all keys, then reset during bit 2.
    sel = 2; en_c = 1'b1; sdo_c = 1'b1;
    repeat (2) @(negedge clk);
    sb_q.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0});
    sb_q.push_back('{16'h0000, 16'h00FF, 1'b1, 1'b1, 4'd0});
    rst_c = 1'b0;
    frame_check("t6.f0", 3000);
    frame_check("t6.f1", 3000);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (falls == 3) begin ok = 1'b1; break; end
    end
    chk("t6.reach_bit2", 32'(ok), 32'd1);
    chk("t6.pre_scl", 32'(scl_c), 32'd0);
    rst_c = 1'b1;
    #1;
    chk("t6.rst_scl", 32'(scl_c), 32'd1);
    chk("t6.rst_key", 32'(key_c), 32'd0);
    chk("t6.rst_any", 32'(any_c), 32'd0);
    @(negedge clk);
    sdo_c = 1'b0;
    rst_c = 1'b0;
    low_samp = 0; low_runs = 0; cur = 0; min_run = 1000; max_run = 0; ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!scl_c) begin
        low_samp++; cur++;
      end else if (cur > 0) begin
        low_runs++;
        if (cur < min_run) min_run = cur;
        if (cur > max_run) max_run = cur;
        cur = 0;
      end
      if (done_c) begin ok = 1'b1; break; end
    end
    chk("t6.done", 32'(ok), 32'd1);
    chk("t6.low_pulses", 32'(low_runs), 32'd8);
    chk("t6.low_samples", 32'(low_samp), 32'd32);
    chk("t6.min_low", 32'(min_run), 32'd4);
    chk("t6.max_low", 32'(max_run), 32'd4);
    @(negedge clk);
    chk("t6.key_after", 32'(key_c), 32'd0);
    rst_c = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
